// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default message widths and check-node
// controller state encoding, common to the check and variable node units.
package ldpc_pkg;

    localparam int data_w_def = 8;
    localparam int ext_w_def  = 3;
    localparam int sum_w_def  = data_w_def + ext_w_def;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cn_state_e;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnu_if.sv
// Message streams of a check node: variable-to-check messages in,
// check-to-variable messages out.
interface cnu_if #(
    parameter int data_w = ldpc_pkg::data_w_def,
    parameter int ext_w  = ldpc_pkg::ext_w_def
);
    localparam int sum_w = data_w + ext_w;

    // Both streams: a word moves on a rising edge where valid and ready are
    // both high; valid never waits on ready, and the payload holds while
    // valid is high and ready is low.
    logic              in_valid;
    logic              in_ready;
    logic [sum_w-1:0]  in_q;
    logic              out_valid;
    logic              out_ready;
    logic [data_w-1:0] out_r;
    logic              out_last;
    logic              par;

    modport master (
        output in_valid, in_q, out_ready,
        input  in_ready, out_valid, out_r, out_last, par
    );

    modport slave (
        input  in_valid, in_q, out_ready,
        output in_ready, out_valid, out_r, out_last, par
    );

endinterface

// File: rtl/mag_sat.sv
// Saturated absolute value of a two's complement message, clipped to the
// largest magnitude an outgoing message can carry.
module mag_sat #(
    parameter int sum_w  = ldpc_pkg::sum_w_def,
    parameter int data_w = ldpc_pkg::data_w_def
) (
    input  logic [sum_w-1:0]  q,
    output logic [data_w-2:0] mag
);
    localparam logic [sum_w-1:0] lim = {{(sum_w - data_w + 1){1'b0}}, {(data_w - 1){1'b1}}};

    logic [sum_w-1:0] a;

    // The most negative input negates to itself, which read unsigned is
    // 2^(sum_w-1) and therefore clips like any other large magnitude.
    assign a   = q[sum_w-1] ? (~q + 1'b1) : q;
    assign mag = (a > lim) ? lim[data_w-2:0] : a[data_w-2:0];

endmodule

// File: rtl/cnu.sv
// Offset-min-sum check node: collects DC messages tracking the two smallest
// magnitudes and the sign parity, then emits one extrinsic message per input.
module cnu
    import ldpc_pkg::*;
#(
    parameter int                data_w = data_w_def,
    parameter int                ext_w  = ext_w_def,
    parameter int                DC     = 6,
    parameter logic [data_w-2:0] OFFSET = '0
) (
    input  logic      clk,
    input  logic      rst,
    cnu_if.slave      bus,
    output cn_state_e dbg_state
);
    localparam int sum_w = data_w + ext_w;
    localparam int kw    = idx_w(DC);
    localparam int mag_w = data_w - 1;

    localparam logic [mag_w-1:0] mag_max = '1;
    localparam logic [kw-1:0]    k_last  = kw'(DC - 1);

    cn_state_e        state, state_n;
    logic [kw-1:0]    k, k_n;
    logic [kw-1:0]    idx, idx_n;
    logic [mag_w-1:0] min1, min1_n;
    logic [mag_w-1:0] min2, min2_n;
    logic [DC-1:0]    signs, signs_n;

    logic [mag_w-1:0] mag;
    logic [mag_w-1:0] m;
    logic [mag_w-1:0] m_off;
    logic             parity;
    logic             out_sign;

    mag_sat #(
        .sum_w  (sum_w),
        .data_w (data_w)
    ) u_mag_sat (
        .q   (bus.in_q),
        .mag (mag)
    );

    assign parity    = ^signs;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            k     <= '0;
            idx   <= '0;
            min1  <= mag_max;
            min2  <= mag_max;
            signs <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
            idx   <= idx_n;
            min1  <= min1_n;
            min2  <= min2_n;
            signs <= signs_n;
        end
    end

    always_comb begin
        state_n       = state;
        k_n           = k;
        idx_n         = idx;
        min1_n        = min1;
        min2_n        = min2;
        signs_n       = signs;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_r     = '0;
        bus.out_last  = 1'b0;
        bus.par       = 1'b0;

        // Extrinsic magnitude: the position holding the minimum sees the
        // runner-up, every other position sees the minimum.
        m        = (k == idx) ? min2 : min1;
        m_off    = (m > OFFSET) ? (m - OFFSET) : '0;
        out_sign = parity ^ signs[k];

        case (state)
            COLLECT: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    signs_n[k] = bus.in_q[sum_w-1];
                    // Strict compares keep the earliest index on ties.
                    if (mag < min1) begin
                        min2_n = min1;
                        min1_n = mag;
                        idx_n  = k;
                    end else if (mag < min2) begin
                        min2_n = mag;
                    end
                    if (k == k_last) begin
                        k_n     = '0;
                        state_n = EMIT;
                    end else begin
                        k_n = k + kw'(1);
                    end
                end
            end
            EMIT: begin
                bus.out_valid = !rst;
                bus.out_r     = out_sign ? -{1'b0, m_off} : {1'b0, m_off};
                bus.out_last  = (k == k_last);
                bus.par       = parity;
                if (bus.out_ready && !rst) begin
                    if (k == k_last) begin
                        state_n = COLLECT;
                        k_n     = '0;
                        idx_n   = '0;
                        min1_n  = mag_max;
                        min2_n  = mag_max;
                        signs_n = '0;
                    end else begin
                        k_n = k + kw'(1);
                    end
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_cnu.sv
// Randomised scoreboard bench for cnu: two instances (offset 0 and 1) share
// one input stream and one output-ready pattern.
module tb_cnu;
    import ldpc_pkg::*;

    localparam int data_w  = 8;
    localparam int ext_w   = 3;
    localparam int sum_w   = data_w + ext_w;
    localparam int DC      = 6;
    localparam int mag_max = 127;
    localparam int ew      = data_w + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnu_if #(.data_w(data_w), .ext_w(ext_w)) bus0 ();
    cnu_if #(.data_w(data_w), .ext_w(ext_w)) bus1 ();
    cn_state_e dbg0, dbg1;

    cnu #(.data_w(data_w), .ext_w(ext_w), .DC(DC), .OFFSET(7'd0)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0), .dbg_state (dbg0)
    );
    cnu #(.data_w(data_w), .ext_w(ext_w), .DC(DC), .OFFSET(7'd1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1), .dbg_state (dbg1)
    );

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_q      = bus0.in_q;
    assign bus1.out_ready = bus0.out_ready;

    logic [ew-1:0] exp_q0[$];
    logic [ew-1:0] exp_q1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int out_k    = 0;
    int stall_cnt = 0;
    bit ready_mode = 0;
    bit held_valid = 0;
    logic [ew-1:0] held;
    int frame[DC];

    task automatic check(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Reference: each output is the smallest magnitude among the other
    // DC-1 inputs (bounded by the saturation limit), less the offset, signed
    // by the product of the other inputs' signs.
    function automatic void model_push(input int v[DC]);
        int mg[DC];
        bit p;
        int m, mo, r;
        bit s;
        p = 0;
        for (int i = 0; i < DC; i++) begin
            mg[i] = (v[i] < 0) ? -v[i] : v[i];
            if (mg[i] > mag_max) mg[i] = mag_max;
            p ^= (v[i] < 0);
        end
        for (int off = 0; off < 2; off++) begin
            for (int k = 0; k < DC; k++) begin
                m = mag_max;
                for (int j = 0; j < DC; j++)
                    if (j != k && mg[j] < m) m = mg[j];
                mo = (m > off) ? m - off : 0;
                s  = p ^ (v[k] < 0);
                r  = s ? -mo : mo;
                if (off == 0) exp_q0.push_back({k == DC - 1, p, 8'(r)});
                else          exp_q1.push_back({k == DC - 1, p, 8'(r)});
            end
        end
    endfunction

    // Driving happens just after a falling edge; returns once the word has
    // been taken by a rising edge.
    task automatic send_word(input int v, input bit last);
        int guard;
        bus0.in_valid = 1'b1;
        bus0.in_q     = v[sum_w-1:0];
        guard = 0;
        while (!bus0.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
                check(0, "in_ready_timeout", 0, 1);
                bus0.in_valid = 1'b0;
                return;
            end
        end
        if (last) model_push(frame);
        @(negedge clk);
    endtask

    task automatic send_frame();
        for (int i = 0; i < DC; i++) send_word(frame[i], i == DC - 1);
        bus0.in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        bus0.in_valid = 1'b0;
        #1;
        check(bus0.in_ready == 1'b0, "in_ready_in_rst", bus0.in_ready, 0);
        check(bus0.out_valid == 1'b0, "out_valid_in_rst", bus0.out_valid, 0);
        repeat (cycles) @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        out_k = 0;
        held_valid = 0;
        stall_cnt = 0;
        rst = 1'b0;
        #1;
        check(bus0.in_ready == 1'b1, "in_ready_after_rst", bus0.in_ready, 1);
        check(dbg0 == COLLECT, "state_after_rst", dbg0, COLLECT);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check(0, "drain_timeout", exp_q0.size(), 0);
                return;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Output-ready pattern: random, or a scripted three-cycle stall at k=2.
    initial begin
        bus0.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!ready_mode) begin
                bus0.out_ready = ($urandom_range(0, 3) != 0);
            end else if (bus0.out_valid && out_k == 2 && stall_cnt < 3) begin
                bus0.out_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus0.out_ready = 1'b1;
            end
        end
    end

    initial begin : monitor0
        logic [ew-1:0] cur, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                cur = {bus0.out_last, bus0.par, bus0.out_r};
                if (bus0.out_valid) begin
                    check(bus0.in_ready == 1'b0, "in_ready_in_emit", bus0.in_ready, 0);
                    if (held_valid) check(cur == held, "stall_hold", int'(cur), int'(held));
                    if (bus0.out_ready) begin
                        if (exp_q0.size() == 0) begin
                            check(0, "unexpected_out0", int'(cur), 0);
                        end else begin
                            e = exp_q0.pop_front();
                            check(cur == e, "out0", int'(cur), int'(e));
                        end
                        out_k = (out_k + 1) % DC;
                        held_valid = 0;
                    end else begin
                        held = cur;
                        held_valid = 1;
                    end
                end else begin
                    check(cur == '0, "idle_zero", int'(cur), 0);
                    held_valid = 0;
                end
            end
        end
    end

    initial begin : monitor1
        logic [ew-1:0] cur, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus1.out_valid && bus1.out_ready) begin
                cur = {bus1.out_last, bus1.par, bus1.out_r};
                if (exp_q1.size() == 0) begin
                    check(0, "unexpected_out1", int'(cur), 0);
                end else begin
                    e = exp_q1.pop_front();
                    check(cur == e, "out1", int'(cur), int'(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        int v;
        bus0.in_valid = 1'b0;
        bus0.in_q     = '0;
        do_reset(3);

        frame = '{5, -3, 7, 2, -9, 4};
        send_frame();
        frame = '{-1024, 500, 200, 200, 200, 200};
        send_frame();
        frame = '{4, 4, 4, 4, 4, 4};
        send_frame();
        wait_drain();

        // Stall at k=2 while the next frame is already being offered.
        ready_mode = 1;
        stall_cnt  = 0;
        frame = '{5, -3, 7, 2, -9, 4};
        send_frame();
        send_frame();
        wait_drain();
        check(stall_cnt == 3, "stall_applied", stall_cnt, 3);
        ready_mode = 0;

        // Partial frame discarded by reset.
        frame = '{1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 3; i++) send_word(frame[i], 0);
        do_reset(1);
        frame = '{5, -3, 7, 2, -9, 4};
        send_frame();
        wait_drain();

        // Reset in the middle of an output frame.
        frame = '{-20, 33, -7, 90, 12, -3};
        send_frame();
        guard = 0;
        while (out_k < 1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check(guard < 500, "emit_start_timeout", guard, 0);
        do_reset(2);
        repeat (10) @(negedge clk);
        check(dbg0 == COLLECT, "state_after_mid_rst", dbg0, COLLECT);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < DC; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    v = int'($urandom_range(0, 40)) - 20;
                end else begin
                    v = int'($urandom_range(0, 2047));
                    if (v >= 1024) v -= 2048;
                end
                frame[i] = v;
            end
            send_frame();
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
